// File: rtl/reg_pkg.sv
// Register-file wide types and sizes shared by the writeback arbiter, register file and datapath.
package reg_pkg;

    localparam int unsigned REG_W      = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 8;

    typedef logic [REG_W-1:0]      reg_data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter with a registered round-robin pointer.
// Define REG_WB_FIXED_PRIO_EN for fixed lowest-index-wins priority (pointer compiled out).
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr;
    logic [PtrW-1:0] idx;
    logic [PtrW-1:0] gnt_idx;
    logic            found;

    // Scan from the pointer upward, wrapping modulo N; first requester found wins.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PtrW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

`ifdef REG_WB_FIXED_PRIO_EN
    logic unused_fixed;

    assign ptr          = '0;
    assign unused_fixed = clk ^ rst_n ^ (^gnt_idx);
`else
    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == PtrW'(N - 1)) ? '0 : gnt_idx + PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter sharing the register-file write port; outputs are registered so they are
// stable at the register file's negedge capture. REG_WB_FIXED_PRIO_EN selects fixed priority.
module reg_wb_arbiter
    import reg_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       freeze,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [REG_ADDR_W*NREQ-1:0] req_reg,
    input  logic [REG_W*NREQ-1:0]      req_data,
    output logic                       wr_en,
    output reg_addr_t                  write_reg,
    output reg_data_t                  write_data,
    output logic [15:0]                write_count
);

    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] gnt;
    logic            transfer;
    reg_addr_t       sel_reg;
    reg_data_t       sel_data;

    logic        wr_en_q, wr_en_d;
    reg_addr_t   write_reg_q, write_reg_d;
    reg_data_t   write_data_q, write_data_d;
    logic [15:0] write_count_q, write_count_d;

    // Masking at the arbiter input keeps the pointer untouched while frozen.
    assign arb_req = freeze ? '0 : req_valid;

    rr_arbiter #(
        .N(NREQ)
    ) u_rr_arbiter (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (arb_req),
        .gnt  (gnt)
    );

    assign req_ready = gnt;
    assign transfer  = |gnt;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_reg  = req_reg[REG_ADDR_W*i +: REG_ADDR_W];
                sel_data = req_data[REG_W*i +: REG_W];
            end
        end
    end

    always_comb begin
        wr_en_d       = transfer;
        write_reg_d   = write_reg_q;
        write_data_d  = write_data_q;
        write_count_d = write_count_q;
        if (transfer) begin
            write_reg_d   = sel_reg;
            write_data_d  = sel_data;
            write_count_d = write_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q       <= 1'b0;
            write_reg_q   <= '0;
            write_data_q  <= '0;
            write_count_q <= '0;
        end else begin
            wr_en_q       <= wr_en_d;
            write_reg_q   <= write_reg_d;
            write_data_q  <= write_data_d;
            write_count_q <= write_count_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign write_reg   = write_reg_q;
    assign write_data  = write_data_q;
    assign write_count = write_count_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: spec-level model checked every cycle plus directed literal checks.
module tb_reg_wb_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          freeze;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [3*N-1:0]  req_reg;
    logic [16*N-1:0] req_data;
    logic          wr_en;
    logic [2:0]    write_reg;
    logic [15:0]   write_data;
    logic [15:0]   write_count;

    int n_pass  = 0;
    int n_total = 0;

    reg_wb_arbiter #(
        .NREQ(N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .freeze     (freeze),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_reg    (req_reg),
        .req_data   (req_data),
        .wr_en      (wr_en),
        .write_reg  (write_reg),
        .write_data (write_data),
        .write_count(write_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Spec model: pointer as an integer, grant by modular scan, outputs as plain variables.
    int          m_ptr;
    logic        m_wr_en;
    logic [2:0]  m_reg;
    logic [15:0] m_data;
    logic [15:0] m_count;
    logic [15:0] rf [8];

    function automatic int exp_grant();
        if (freeze) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   <= 0;
            m_wr_en <= 1'b0;
            m_reg   <= '0;
            m_data  <= '0;
            m_count <= '0;
        end else begin
            int g;
            g = exp_grant();
            if (g >= 0) begin
                m_wr_en <= 1'b1;
                m_reg   <= req_reg[3*g +: 3];
                m_data  <= req_data[16*g +: 16];
                m_count <= m_count + 16'd1;
`ifndef REG_WB_FIXED_PRIO_EN
                m_ptr   <= (g + 1) % N;
`endif
            end else begin
                m_wr_en <= 1'b0;
            end
        end
    end

    // Compare process plus a stand-in register file capturing at negedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            int g;
            logic [N-1:0] exp_rdy;
            g = exp_grant();
            exp_rdy = (g >= 0) ? N'(1 << g) : '0;
            chk("model_ready", 32'(req_ready), 32'(exp_rdy));
            chk("model_wr_en", 32'(wr_en), 32'(m_wr_en));
            chk("model_write_reg", 32'(write_reg), 32'(m_reg));
            chk("model_write_data", 32'(write_data), 32'(m_data));
            chk("model_write_count", 32'(write_count), 32'(m_count));
        end
        if (wr_en === 1'b1) rf[write_reg] = write_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] order [6];

    initial begin
`ifdef REG_WB_FIXED_PRIO_EN
        for (int i = 0; i < 6; i++) order[i] = 3'b001;
`else
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
        order[3] = 3'b001; order[4] = 3'b010; order[5] = 3'b100;
`endif
        for (int i = 0; i < 8; i++) rf[i] = '0;
        rst_n = 1'b0; freeze = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
        step(); step();
        rst_n = 1'b1;
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_write_reg", 32'(write_reg), 0);
        chk("reset_write_data", 32'(write_data), 0);
        chk("reset_count", 32'(write_count), 0);

        // Single request: requester 1 writes r5 = BEEF.
        req_valid = 3'b010; req_reg[5:3] = 3'd5; req_data[31:16] = 16'hBEEF;
        #1 chk("single_ready", 32'(req_ready), 32'b010);
        step();
        req_valid = '0;
        chk("single_wr_en", 32'(wr_en), 1);
        chk("single_reg", 32'(write_reg), 5);
        chk("single_data", 32'(write_data), 32'hBEEF);
        chk("single_count", 32'(write_count), 1);
        @(negedge clk); #1;
        chk("single_rf_r5", 32'(rf[5]), 32'hBEEF);
        step();
        chk("single_wr_en_drop", 32'(wr_en), 0);

        // Reset in the middle of a pending write.
        req_valid = 3'b111;
        req_reg   = {3'd3, 3'd2, 3'd1};
        req_data  = {16'hC000, 16'hB000, 16'hA000};
        step();
        chk("pre_reset_wr_en", 32'(wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_wr_en", 32'(wr_en), 0);
        chk("async_reset_count", 32'(write_count), 0);
        chk("async_reset_reg", 32'(write_reg), 0);
        step();
        rst_n = 1'b1;

        // Contention: all valid for 6 cycles, starting from pointer 0.
        for (int c = 0; c < 6; c++) begin
            chk("contention_grant", 32'(req_ready), 32'(order[c]));
            step();
            chk("contention_wr_en", 32'(wr_en), 1);
        end
        req_valid = '0;
        chk("contention_count", 32'(write_count), 6);
        step();

        // Same-target race on r2.
        req_valid = 3'b101;
        req_reg   = {3'd2, 3'd0, 3'd2};
        req_data  = {16'h2222, 16'h0000, 16'h1111};
        #1 chk("race_first_ready", 32'(req_ready), 32'b001);
        step();
        req_valid = 3'b100;
        chk("race_first_data", 32'(write_data), 32'h1111);
        @(negedge clk); #1;
        chk("race_rf_r2_first", 32'(rf[2]), 32'h1111);
        step();
        req_valid = '0;
        chk("race_second_data", 32'(write_data), 32'h2222);
        @(negedge clk); #1;
        chk("race_rf_r2_final", 32'(rf[2]), 32'h2222);
        step();

        // Freeze with requests 1 and 2 pending.
        freeze = 1'b1; req_valid = 3'b110;
        for (int c = 0; c < 3; c++) begin
            #1 chk("freeze_ready", 32'(req_ready), 0);
            step();
            chk("freeze_wr_en", 32'(wr_en), 0);
        end
        freeze = 1'b0;
        #1 chk("unfreeze_ready", 32'(req_ready), 32'b010);
        step();
        req_valid = 3'b100;
        chk("unfreeze_wr_en", 32'(wr_en), 1);
        chk("unfreeze_ready2", 32'(req_ready), 32'b100);
        step();
        req_valid = '0;
        step();

        // Counter wrap: clear, 65535 writes, then one more.
        rst_n = 1'b0; #1; step(); rst_n = 1'b1;
        req_valid = 3'b001; req_reg[2:0] = 3'd7;
        for (int c = 0; c < 65535; c++) begin
            req_data[15:0] = 16'(c);
            step();
        end
        chk("wrap_preload_count", 32'(write_count), 32'hFFFF);
        req_data[15:0] = 16'h5A5A;
        step();
        req_valid = '0;
        chk("wrap_count_zero", 32'(write_count), 0);
        chk("wrap_wr_en", 32'(wr_en), 1);
        chk("wrap_data", 32'(write_data), 32'h5A5A);
        step();
        chk("wrap_idle_wr_en", 32'(wr_en), 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Shares the single write port of the 8×16 register file between up to NREQ writeback requesters, such as the ALU result path, the load unit and the immediate/move path. It runs round-robin arbitration over valid/ready request channels and drives `wr_en`, `write_reg` and `write_data` from registers. Those outputs are stable across the register file's negedge capture point. It also keeps a running count of committed writes for debug and performance.

## Interface
- `NREQ`, default 3: number of requesters, legal range 2..4.
- `clk` input 1: single clock. All state updates on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `freeze` input 1: when high, no request is granted.
- `req_valid` input NREQ: per-requester request valid.
- `req_ready` output NREQ: per-requester grant, combinational.
- `req_reg` input 3*NREQ: target register index. Requester i uses bits [3i+2:3i].
- `req_data` input 16*NREQ: write data. Requester i uses bits [16i+15:16i].
- `wr_en` output 1: registered write enable to the register file.
- `write_reg` output 3: registered write index.
- `write_data` output 16: registered write data.
- `write_count` output 16: number of committed writes, wraps at 16 bits.

## Operation
- Transfer on requester i: `req_valid[i] & req_ready[i]` sampled at posedge.
- Requester rules:
  - Once `req_valid[i]` is raised, it holds, with `req_reg` and `req_data` stable, until the transfer.
  - `req_valid` must not depend on `req_ready`.
- Grant (combinational):
  - If `freeze`=1 or no valid request, all `req_ready`=0.
  - Otherwise exactly one bit is set: the first valid requester scanning from `rr_ptr` upward, modulo NREQ.
- Pointer update on a transfer by requester i: `rr_ptr` ← (i+1) mod NREQ. With no transfer, `rr_ptr` is unchanged.
- Output registers:
  - On a transfer: `wr_en`←1, `write_reg`←`req_reg[i]`, `write_data`←`req_data[i]`, `write_count`←`write_count`+1 (mod 2^16).
  - With no transfer: `wr_en`←0. `write_reg` and `write_data` hold their previous values.
- Same target: two requesters may target the same register in one cycle. Only the granted one writes; the other writes in a later cycle, so the later grant wins the final value.
- No dependency checking or forwarding. Ordering between requesters is the pipeline's responsibility.
- Reset values: `wr_en`=0, `write_reg`=0, `write_data`=0, `write_count`=0, `rr_ptr`=0.
- Reset mid-operation: any pending output write is dropped (`wr_en` clears immediately, asynchronously). Requests still valid after reset deassertion are re-arbitrated from `rr_ptr`=0.

## Timing
- Accept-to-write latency:
  - A transfer at the posedge ending cycle N sets `wr_en` for cycle N+1.
  - The register file captures the write at the negedge inside cycle N+1.
  - Read ports reflect the new value from the second half of cycle N+1.
- Throughput: one write per cycle. Back-to-back grants produce a continuous `wr_en`.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,… Maximum wait is NREQ-1 cycles.
- `freeze`:
  - Takes effect in the same cycle: `req_ready`=0, and `wr_en`=0 in the next cycle.
  - When `freeze` falls, arbitration resumes from the unchanged `rr_ptr`.
- No combinational path from `req_*` to `wr_en`, `write_reg`, `write_data` or `write_count`.

## Configuration
- `REG_WB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. `rr_ptr` logic is compiled out and the pointer is treated as constant 0. Starvation of high-index requesters is permitted.
  - Undefined (default): round-robin as described above.

## Structure
- Package `reg_pkg`:
  - `REG_W`=16, `REG_ADDR_W`=3, `NUM_REGS`=8.
  - Typedefs `reg_data_t` and `reg_addr_t`, shared with the register file and the datapath.
- Sub-module `rr_arbiter` (parameter N):
  - Combinational one-hot grant from the request vector and pointer.
  - Owns the pointer register and its async reset.
  - Contains the `REG_WB_FIXED_PRIO_EN` switch.
- `reg_wb_arbiter` contains the output registers, the counter, and the payload mux.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with requesters valid → `wr_en`=0, `write_count`=0, `write_reg`=0 at once. After release, requester 0 is granted first.
- Single request: requester 1 writes r5=16'hBEEF → `req_ready[1]`=1 for one cycle; next cycle `wr_en`=1, `write_reg`=5, `write_data`=16'hBEEF; register file read of r5 returns 16'hBEEF in that cycle's second half; `write_count`=1.
- Contention, round-robin: all 3 requesters held valid for 6 cycles → grant order 0,1,2,0,1,2, continuous `wr_en`, `write_count`=6. With `REG_WB_FIXED_PRIO_EN` defined → requester 0 granted all 6 cycles.
- Same-target race: requester 0 writes r2=1111 and requester 2 writes r2=2222 in the same cycle, with `rr_ptr`=0 → r2 is 1111, then 2222 one cycle later.
- Freeze: `freeze`=1 for 3 cycles with requests pending → `req_ready`=0 and `wr_en`=0 throughout, pointer unchanged. Grants resume on the cycle `freeze` falls.
- Counter wrap: preload by running 65535 writes, then one more write → `write_count` wraps to 0 and `wr_en` behaviour is unaffected.
